mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Memory-stage data-access sequencer for the 5-stage RISC-V core.
- Takes the load/store held in the E->M pipeline register and runs it over a req/ack data-memory bus, which may take multiple cycles.
- Stalls F/D/E/M and bubbles W until the access completes.
- Formats byte/half/word load data and store lanes, and flags misaligned accesses and bus timeouts.

Parameters:
- TIMEOUT, 255, maximum number of BUSY cycles to wait for mem_ack before aborting; valid range 1..65535.
- CNT_W, 16, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- CLK  in  1  core clock
- RST  in  1  synchronous active-high reset
- MemWriteM  in  1  store in M
- ResultSrcM  in  3  3'b001 means load in M
- Byte_Half_OpM  in  2  access size: 00 word, 01 byte, 10 half, 11 treated as word
- signM  in  1  1 = sign-extend load, 0 = zero-extend
- ALUResultM  in  32  byte address
- WriteDataM  in  32  store data
- mem_req  out  1  bus request
- mem_we  out  1  1 = write
- mem_addr  out  32  word address {ALUResultM[31:2],2'b00}
- mem_wdata  out  32  store data replicated to lanes
- mem_be  out  4  byte enables
- mem_ack  in  1  bus completion (single-cycle pulse)
- mem_rdata  in  32  read word, valid with mem_ack
- ReadDataM  out  32  formatted load data
- StallF, StallD, StallE, StallM  out  1 each  hold the pipeline registers
- FlushW  out  1  bubble into M->W
- MisalignM  out  1  misaligned access
- TimeoutM  out  1  bus timeout pulse

Behaviour:
- AccessM = MemWriteM | (ResultSrcM==3'b001).
- MisalignM (combinational) = AccessM & ((half & addr[0]) | (word & addr[1:0]!=0)).
  - A misaligned access issues no request and raises no stall.
- FSM states: IDLE, BUSY, DONE, ERR. Reset state is IDLE.
- IDLE:
  - If AccessM & ~MisalignM, go to BUSY.
  - On that transition, register mem_we, mem_addr, mem_wdata and mem_be, and clear the counter.
- BUSY:
  - mem_req=1; bus fields hold stable.
  - On mem_ack: capture the formatted mem_rdata into ReadDataM (loads only) and go to DONE.
  - Otherwise increment the counter. When counter==TIMEOUT-1 with no ack, go to ERR.
  - If mem_ack arrives in the same cycle the counter hits its limit, ack wins.
- DONE: one cycle, stalls low so the M instruction advances; next state is IDLE.
- ERR: one cycle, TimeoutM=1, stalls low; ReadDataM is unchanged; next state is IDLE.
- Stall (all four outputs and FlushW) = (state==IDLE & AccessM & ~MisalignM) | state==BUSY.
  - This is combinational from state and inputs.
- Latency:
  - Ack in the first BUSY cycle gives 2 stall cycles; the instruction leaves M on the 3rd edge.
  - Each extra BUSY cycle adds one stall cycle.
- Back-to-back accesses: after DONE, the next M instruction is seen in IDLE with no gap cycle.
- mem_req=0 in IDLE, DONE and ERR. mem_ack outside BUSY is ignored.
- Store lanes:
  - byte: wdata={4{WriteDataM[7:0]}}, be=4'b0001<<addr[1:0].
  - half: wdata={2{WriteDataM[15:0]}}, be=addr[1]?4'b1100:4'b0011.
  - word: wdata=WriteDataM, be=4'b1111.
- Loads: mem_be is set as for stores of the same size (informational); mem_we=0.
- Load formatting:
  - byte lane = addr[1:0]; half lane = addr[1].
  - Extend to 32 bits per signM.
  - Word is passed through unchanged.
- Reset values: state IDLE; mem_req 0; mem_we 0; mem_addr, mem_wdata, mem_be 0; counter 0; ReadDataM 0; TimeoutM 0.
  - Stall outputs follow their equation, so they are 0 unless an access is present in IDLE.
- Reset asserted mid-BUSY: the next cycle is IDLE with mem_req=0; the outstanding bus transaction is abandoned.

Test Plan:
- LW addr 0x100, mem_ack on the 1st BUSY cycle with rdata 0xDEADBEEF -> mem_req high 1 cycle, stalls high 2 cycles, ReadDataM=0xDEADBEEF.
- LB signM=1 addr 0x103, rdata 0x80FF_0000 -> mem_addr=0x100, ReadDataM=0xFFFFFF80; LBU (signM=0) -> 0x00000080.
- SH addr 0x202 data 0x0000ABCD, ack after 4 cycles -> mem_we=1, be=4'b1100, wdata=0xABCDABCD, stalls high 5 cycles.
- LW addr 0x101 -> MisalignM=1, mem_req never asserted, stalls 0.
- TIMEOUT=4, no ack -> 4 BUSY cycles, then TimeoutM=1 for 1 cycle, stalls drop, FSM returns to IDLE.
- RST during BUSY -> next cycle mem_req=0, state IDLE, ReadDataM=0; a subsequent SW completes normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// Memory-stage data-access sequencer: runs the M-stage load/store over a
// req/ack bus, stalls the pipeline while busy, formats load/store lanes.
module mem_access_ctrl #(
    parameter int TIMEOUT = 255,
    parameter int CNT_W   = 16
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic        MemWriteM,
    input  logic [2:0]  ResultSrcM,
    input  logic [1:0]  Byte_Half_OpM,
    input  logic        signM,
    input  logic [31:0] ALUResultM,
    input  logic [31:0] WriteDataM,
    output logic        mem_req,
    output logic        mem_we,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wdata,
    output logic [3:0]  mem_be,
    input  logic        mem_ack,
    input  logic [31:0] mem_rdata,
    output logic [31:0] ReadDataM,
    output logic        StallF,
    output logic        StallD,
    output logic        StallE,
    output logic        StallM,
    output logic        FlushW,
    output logic        MisalignM,
    output logic        TimeoutM
);

    typedef enum logic [1:0] {IDLE, BUSY, DONE, ERR} state_t;

    state_t            state, state_nxt;
    logic              access, byte_op, half_op, word_op, start, stall;
    logic [CNT_W-1:0]  cnt;
    logic              cnt_hit;
    logic [3:0]        be_nxt;
    logic [31:0]       wdata_nxt;
    logic [31:0]       rd_fmt;
    logic [7:0]        rd_byte;
    logic [15:0]       rd_half;
    // Access shape kept for formatting the returned word.
    logic [1:0]        off_q;
    logic              byte_q, half_q, sign_q;

    assign access  = MemWriteM | (ResultSrcM == 3'b001);
    assign byte_op = (Byte_Half_OpM == 2'b01);
    assign half_op = (Byte_Half_OpM == 2'b10);
    assign word_op = ~byte_op & ~half_op;

    assign MisalignM = access & ((half_op & ALUResultM[0]) |
                                 (word_op & (ALUResultM[1:0] != 2'b00)));
    assign start     = access & ~MisalignM;
    assign cnt_hit   = (cnt == CNT_W'(TIMEOUT - 1));

    // Store lane steering
    always_comb begin
        be_nxt    = 4'b1111;
        wdata_nxt = WriteDataM;
        if (byte_op) begin
            be_nxt    = 4'b0001 << ALUResultM[1:0];
            wdata_nxt = {4{WriteDataM[7:0]}};
        end else if (half_op) begin
            be_nxt    = ALUResultM[1] ? 4'b1100 : 4'b0011;
            wdata_nxt = {2{WriteDataM[15:0]}};
        end
    end

    // Load lane extraction and extension
    always_comb begin
        case (off_q)
            2'd0:    rd_byte = mem_rdata[7:0];
            2'd1:    rd_byte = mem_rdata[15:8];
            2'd2:    rd_byte = mem_rdata[23:16];
            default: rd_byte = mem_rdata[31:24];
        endcase
        rd_half = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
        rd_fmt  = mem_rdata;
        if (byte_q)
            rd_fmt = {{24{sign_q & rd_byte[7]}}, rd_byte};
        else if (half_q)
            rd_fmt = {{16{sign_q & rd_half[15]}}, rd_half};
    end

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = BUSY;
            BUSY:    if (mem_ack)      state_nxt = DONE;
                     else if (cnt_hit) state_nxt = ERR;
            DONE:    state_nxt = IDLE;
            ERR:     state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        mem_req  = (state == BUSY);
        TimeoutM = (state == ERR);
        stall    = ((state == IDLE) & start) | (state == BUSY);
        StallF   = stall;
        StallD   = stall;
        StallE   = stall;
        StallM   = stall;
        FlushW   = stall;
    end

    // Bus fields latch on entry to BUSY and hold until the next access.
    always_ff @(posedge CLK) begin
        if (RST) begin
            mem_we    <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            mem_be    <= '0;
            cnt       <= '0;
            ReadDataM <= '0;
            off_q     <= '0;
            byte_q    <= 1'b0;
            half_q    <= 1'b0;
            sign_q    <= 1'b0;
        end else begin
            if (state == IDLE && start) begin
                mem_we    <= MemWriteM;
                mem_addr  <= {ALUResultM[31:2], 2'b00};
                mem_wdata <= wdata_nxt;
                mem_be    <= be_nxt;
                cnt       <= '0;
                off_q     <= ALUResultM[1:0];
                byte_q    <= byte_op;
                half_q    <= half_op;
                sign_q    <= signM;
            end
            if (state == BUSY) begin
                if (mem_ack) begin
                    if (!mem_we) ReadDataM <= rd_fmt;
                end else begin
                    cnt <= cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Scenario bench for mem_access_ctrl: a bus responder acks after a chosen
// number of BUSY cycles; expected load results go through a scoreboard queue.
module tb_mem_access_ctrl;

    logic        CLK = 1'b0;
    logic        RST;
    logic        MemWriteM;
    logic [2:0]  ResultSrcM;
    logic [1:0]  Byte_Half_OpM;
    logic        signM;
    logic [31:0] ALUResultM, WriteDataM;
    logic        mem_req, mem_we, mem_ack;
    logic [31:0] mem_addr, mem_wdata, mem_rdata, ReadDataM;
    logic [3:0]  mem_be;
    logic        StallF, StallD, StallE, StallM, FlushW, MisalignM, TimeoutM;

    int npass = 0;
    int ntotal = 0;
    logic [31:0] exp_q[$];
    logic [31:0] rd_model = 32'h0;

    // Results of the last do_access call
    int          stall_n, req_n;
    logic [31:0] rd, a_addr, a_wdata, exp_v;
    logic [3:0]  a_be;
    logic        a_we, tout, stable, fin;

    always #5 CLK = ~CLK;

    mem_access_ctrl #(.TIMEOUT(4), .CNT_W(16)) dut (
        .CLK(CLK), .RST(RST), .MemWriteM(MemWriteM), .ResultSrcM(ResultSrcM),
        .Byte_Half_OpM(Byte_Half_OpM), .signM(signM), .ALUResultM(ALUResultM),
        .WriteDataM(WriteDataM), .mem_req(mem_req), .mem_we(mem_we),
        .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
        .mem_ack(mem_ack), .mem_rdata(mem_rdata), .ReadDataM(ReadDataM),
        .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
        .FlushW(FlushW), .MisalignM(MisalignM), .TimeoutM(TimeoutM)
    );

    task automatic drop_inputs();
        MemWriteM = 1'b0; ResultSrcM = 3'b000; Byte_Half_OpM = 2'b00;
        signM = 1'b0; ALUResultM = '0; WriteDataM = '0; mem_ack = 1'b0;
    endtask

    task automatic idle(input int n);
        drop_inputs();
        repeat (n) begin @(negedge CLK); #1; end
    endtask

    // Called just after a falling edge. Presents one M-stage access and
    // answers the bus, acking on BUSY cycle ack_at (0 = never). With cont=1
    // the inputs are presented while the previous access is still in DONE.
    task automatic do_access(input logic we, input logic [1:0] sz, input logic sg,
                             input logic [31:0] addr, input logic [31:0] wd,
                             input logic [31:0] rdat, input int ack_at, input logic cont);
        stall_n = 0; req_n = 0; fin = 1'b0; stable = 1'b1; tout = 1'b0;
        rd = '0; a_addr = '0; a_wdata = '0; a_be = '0; a_we = 1'b0;
        MemWriteM = we; ResultSrcM = we ? 3'b000 : 3'b001;
        Byte_Half_OpM = sz; signM = sg; ALUResultM = addr; WriteDataM = wd;
        mem_ack = 1'b0;
        if (cont) @(negedge CLK);
        #1;
        for (int c = 0; c < 40 && !fin; c++) begin
            if (c > 0) begin @(negedge CLK); #1; end
            mem_ack = 1'b0;
            if ({StallF, StallD, StallE, FlushW} != {4{StallM}}) stable = 1'b0;
            if (StallM) stall_n++;
            if (mem_req) begin
                req_n++;
                if (req_n == 1) begin
                    a_addr = mem_addr; a_wdata = mem_wdata; a_be = mem_be; a_we = mem_we;
                end else if ({mem_addr, mem_wdata, mem_be, mem_we} !== {a_addr, a_wdata, a_be, a_we})
                    stable = 1'b0;
                if (req_n == ack_at) begin mem_ack = 1'b1; mem_rdata = rdat; end
                else mem_rdata = $urandom;
            end
            if (!StallM && !mem_req) begin
                fin = 1'b1; rd = ReadDataM; tout = TimeoutM;
            end
        end
    endtask

    task automatic test_reset();
        RST = 1'b1; drop_inputs(); mem_rdata = '0;
        repeat (2) begin @(negedge CLK); #1; end
        ntotal++;
        if ({mem_req, mem_we, mem_be, TimeoutM, StallM, FlushW} !== 9'd0)
            $display("FAIL reset_ctrl got %b want 0", {mem_req, mem_we, mem_be, TimeoutM, StallM, FlushW});
        else npass++;
        ntotal++;
        if ({mem_addr, mem_wdata, ReadDataM} !== 96'd0)
            $display("FAIL reset_data got %h %h %h want 0", mem_addr, mem_wdata, ReadDataM);
        else npass++;
        RST = 1'b0;
        idle(1);
    endtask

    task automatic test_lw();
        exp_q.push_back(32'hDEADBEEF);
        do_access(1'b0, 2'b00, 1'b0, 32'h100, 32'h0, 32'hDEADBEEF, 1, 1'b0);
        ntotal++;
        if (!fin || stall_n != 2 || req_n != 1 || tout || !stable)
            $display("FAIL lw_timing got fin=%0b stalls=%0d reqs=%0d to=%0b st=%0b want 1/2/1/0/1", fin, stall_n, req_n, tout, stable);
        else npass++;
        ntotal++;
        if ({a_addr, a_we, a_be} !== {32'h100, 1'b0, 4'b1111})
            $display("FAIL lw_bus got %h %b %b want 00000100 0 1111", a_addr, a_we, a_be);
        else npass++;
        exp_v = exp_q.pop_front(); rd_model = exp_v;
        ntotal++;
        if (rd !== exp_v) $display("FAIL lw_data got %h want %h", rd, exp_v);
        else npass++;
        idle(1);
    endtask

    task automatic test_lb();
        exp_q.push_back(32'hFFFFFF80);
        do_access(1'b0, 2'b01, 1'b1, 32'h103, 32'h0, 32'h80FF0000, 2, 1'b0);
        ntotal++;
        if (!fin || stall_n != 3 || req_n != 2 || {a_addr, a_be} !== {32'h100, 4'b1000})
            $display("FAIL lb_bus got fin=%0b stalls=%0d reqs=%0d addr=%h be=%b want 1/3/2/00000100/1000", fin, stall_n, req_n, a_addr, a_be);
        else npass++;
        exp_v = exp_q.pop_front(); rd_model = exp_v;
        ntotal++;
        if (rd !== exp_v) $display("FAIL lb_data got %h want %h", rd, exp_v);
        else npass++;
        idle(1);
        exp_q.push_back(32'h00000080);
        do_access(1'b0, 2'b01, 1'b0, 32'h103, 32'h0, 32'h80FF0000, 1, 1'b0);
        exp_v = exp_q.pop_front(); rd_model = exp_v;
        ntotal++;
        if (!fin || rd !== exp_v) $display("FAIL lbu_data got %h want %h", rd, exp_v);
        else npass++;
        idle(1);
    endtask

    task automatic test_store();
        // Ack lands on the same BUSY cycle the wait counter reaches its limit.
        exp_q.push_back(rd_model);
        do_access(1'b1, 2'b10, 1'b0, 32'h202, 32'h0000ABCD, 32'h0, 4, 1'b0);
        ntotal++;
        if (!fin || stall_n != 5 || req_n != 4 || tout || !stable)
            $display("FAIL sh_timing got fin=%0b stalls=%0d reqs=%0d to=%0b st=%0b want 1/5/4/0/1", fin, stall_n, req_n, tout, stable);
        else npass++;
        ntotal++;
        if ({a_addr, a_we, a_be, a_wdata} !== {32'h200, 1'b1, 4'b1100, 32'hABCDABCD})
            $display("FAIL sh_bus got %h %b %b %h want 00000200 1 1100 abcdabcd", a_addr, a_we, a_be, a_wdata);
        else npass++;
        exp_v = exp_q.pop_front();
        ntotal++;
        if (rd !== exp_v) $display("FAIL sh_keep_rd got %h want %h", rd, exp_v);
        else npass++;
        idle(1);
        do_access(1'b1, 2'b01, 1'b0, 32'h011, 32'h1234565A, 32'h0, 1, 1'b0);
        ntotal++;
        if (!fin || {a_addr, a_we, a_be, a_wdata} !== {32'h010, 1'b1, 4'b0010, 32'h5A5A5A5A})
            $display("FAIL sb_bus got %h %b %b %h want 00000010 1 0010 5a5a5a5a", a_addr, a_we, a_be, a_wdata);
        else npass++;
        idle(1);
    endtask

    task automatic test_misalign();
        MemWriteM = 1'b0; ResultSrcM = 3'b001; Byte_Half_OpM = 2'b00; ALUResultM = 32'h101;
        for (int c = 0; c < 3; c++) begin
            @(negedge CLK); #1;
            ntotal++;
            if ({MisalignM, mem_req, StallM} !== 3'b100)
                $display("FAIL lw_misalign got mis=%b req=%b stall=%b want 1 0 0", MisalignM, mem_req, StallM);
            else npass++;
        end
        // Size 11 behaves as word; aligned half and odd byte are legal.
        Byte_Half_OpM = 2'b11; ALUResultM = 32'h102; #1;
        ntotal++;
        if (MisalignM !== 1'b1) $display("FAIL sz11_misalign got %b want 1", MisalignM);
        else npass++;
        Byte_Half_OpM = 2'b10; ALUResultM = 32'h201; MemWriteM = 1'b1; ResultSrcM = 3'b000; #1;
        ntotal++;
        if (MisalignM !== 1'b1) $display("FAIL sh_misalign got %b want 1", MisalignM);
        else npass++;
        ALUResultM = 32'h202; #1;
        ntotal++;
        if (MisalignM !== 1'b0) $display("FAIL sh_aligned got %b want 0", MisalignM);
        else npass++;
        drop_inputs(); #1;
        ntotal++;
        if (MisalignM !== 1'b0) $display("FAIL noaccess_misalign got %b want 0", MisalignM);
        else npass++;
        idle(1);
    endtask

    task automatic test_timeout();
        exp_q.push_back(rd_model);
        do_access(1'b0, 2'b00, 1'b0, 32'h300, 32'h0, 32'h0, 0, 1'b0);
        ntotal++;
        if (!fin || stall_n != 5 || req_n != 4 || tout !== 1'b1)
            $display("FAIL timeout_seq got fin=%0b stalls=%0d reqs=%0d to=%0b want 1/5/4/1", fin, stall_n, req_n, tout);
        else npass++;
        exp_v = exp_q.pop_front();
        ntotal++;
        if (rd !== exp_v) $display("FAIL timeout_keep_rd got %h want %h", rd, exp_v);
        else npass++;
        // Stray ack in IDLE must not start anything.
        drop_inputs(); mem_ack = 1'b1;
        @(negedge CLK); #1; mem_ack = 1'b0;
        ntotal++;
        if ({TimeoutM, mem_req, StallM} !== 3'b000)
            $display("FAIL timeout_after got to=%b req=%b stall=%b want 0 0 0", TimeoutM, mem_req, StallM);
        else npass++;
        idle(1);
        ntotal++;
        if ({TimeoutM, mem_req, ReadDataM} !== {2'b00, rd_model})
            $display("FAIL stray_ack got to=%b req=%b rd=%h want 0 0 %h", TimeoutM, mem_req, ReadDataM, rd_model);
        else npass++;
    endtask

    task automatic test_back_to_back();
        exp_q.push_back(32'hFFFF8001);
        exp_q.push_back(32'h00008001);
        do_access(1'b0, 2'b10, 1'b1, 32'h402, 32'h0, 32'h80010000, 1, 1'b0);
        exp_v = exp_q.pop_front();
        ntotal++;
        if (!fin || stall_n != 2 || rd !== exp_v)
            $display("FAIL b2b_lh got fin=%0b stalls=%0d rd=%h want 1/2/%h", fin, stall_n, rd, exp_v);
        else npass++;
        do_access(1'b0, 2'b10, 1'b0, 32'h400, 32'h0, 32'h00008001, 1, 1'b1);
        exp_v = exp_q.pop_front(); rd_model = exp_v;
        ntotal++;
        if (!fin || stall_n != 2 || req_n != 1 || rd !== exp_v)
            $display("FAIL b2b_lhu got fin=%0b stalls=%0d reqs=%0d rd=%h want 1/2/1/%h", fin, stall_n, req_n, rd, exp_v);
        else npass++;
        idle(1);
    endtask

    task automatic test_reset_busy();
        int w;
        MemWriteM = 1'b0; ResultSrcM = 3'b001; Byte_Half_OpM = 2'b00; ALUResultM = 32'h500;
        w = 0;
        while (!mem_req && w < 10) begin @(negedge CLK); #1; w++; end
        ntotal++;
        if (mem_req !== 1'b1) $display("FAIL rstbusy_enter got req=%b want 1", mem_req);
        else npass++;
        RST = 1'b1; drop_inputs();
        @(negedge CLK); #1;
        ntotal++;
        if ({mem_req, StallM, TimeoutM, ReadDataM} !== 35'd0)
            $display("FAIL rstbusy_state got req=%b stall=%b to=%b rd=%h want 0 0 0 0", mem_req, StallM, TimeoutM, ReadDataM);
        else npass++;
        RST = 1'b0; rd_model = 32'h0;
        idle(1);
        exp_q.push_back(rd_model);
        do_access(1'b1, 2'b00, 1'b0, 32'h304, 32'h12345678, 32'h0, 2, 1'b0);
        ntotal++;
        if (!fin || stall_n != 3 || {a_addr, a_we, a_be, a_wdata} !== {32'h304, 1'b1, 4'b1111, 32'h12345678})
            $display("FAIL sw_after_rst got fin=%0b stalls=%0d %h %b %b %h want 1/3 00000304 1 1111 12345678", fin, stall_n, a_addr, a_we, a_be, a_wdata);
        else npass++;
        exp_v = exp_q.pop_front();
        ntotal++;
        if (rd !== exp_v) $display("FAIL sw_keep_rd got %h want %h", rd, exp_v);
        else npass++;
        idle(2);
    endtask

    initial begin
        test_reset();
        test_lw();
        test_lb();
        test_store();
        test_misalign();
        test_timeout();
        test_back_to_back();
        test_reset_busy();
        $display("%0d/%0d checks passed", npass, ntotal);
        $finish;
    end

endmodule
